// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order fetch-to-decode instruction queue with request credit
//
// Purpose:
//   Reserves a slot when fetch issues a request and records its PC.
//   Fills the oldest reserved slot when the instruction returns.
//   Presents filled entries to decode in order, using a valid/ack handshake.
//   The pc_id_available credit keeps fetch from issuing more requests than
//   the buffer can hold.
//
// Ports:
//   clk                  clock, all state on posedge
//   rst                  asynchronous active-low reset
//   flush                drop every reserved and filled entry
//   pc_id_available      a free slot exists (registered state only)
//   pc_id_assigned       fetch issued a request this cycle
//   issue_pc             PC of that request
//   fetch_complete       oldest outstanding request returns this cycle
//   fetch_instruction    returned instruction word
//   fetch_address_valid  0 marks the returned entry as a fetch fault
//   decode_valid         head entry is filled
//   decode_pc            head PC (0 when not valid)
//   decode_instruction   head instruction (0 when not valid)
//   decode_fetch_fault   head fault flag (0 when not valid)
//   decode_ack           decode consumes the head this cycle
//   occupancy            reserved + filled entries
//   protocol_error       sticky: completion arrived with nothing outstanding

module fetch_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   output logic                       pc_id_available,
   input  logic                       pc_id_assigned,
   input  logic [31:0]                issue_pc,
   input  logic                       fetch_complete,
   input  logic [31:0]                fetch_instruction,
   input  logic                       fetch_address_valid,
   output logic                       decode_valid,
   output logic [31:0]                decode_pc,
   output logic [31:0]                decode_instruction,
   output logic                       decode_fetch_fault,
   input  logic                       decode_ack,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       protocol_error
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   // Pointers carry one extra wrap bit so full (alloc - head = DEPTH) and
   // empty (alloc = head) remain distinguishable.
   logic [PW-1:0] head;
   logic [PW-1:0] fill;
   logic [PW-1:0] alloc;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic        fault_mem [DEPTH];

   logic do_reserve;
   logic do_fill;
   logic do_pop;
   logic bad_fill;

   // Fill uses the registered fill/alloc pointers, so a reservation made in
   // the same cycle can never be consumed by that cycle's completion.
   assign do_reserve = pc_id_assigned && !flush;
   assign do_fill    = fetch_complete && !flush && (fill != alloc);
   assign bad_fill   = fetch_complete && !flush && (fill == alloc);
   assign do_pop     = decode_valid && decode_ack && !flush;

   assign occupancy       = alloc - head;
   assign pc_id_available = (occupancy != PW'(DEPTH));
   assign decode_valid    = (head != fill);

   always_comb begin
      decode_pc          = 32'd0;
      decode_instruction = 32'd0;
      decode_fetch_fault = 1'b0;
      if (decode_valid) begin
         decode_pc          = pc_mem[head[IW-1:0]];
         decode_instruction = instr_mem[head[IW-1:0]];
         decode_fetch_fault = fault_mem[head[IW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head           <= '0;
         fill           <= '0;
         alloc          <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (flush) begin
            head  <= '0;
            fill  <= '0;
            alloc <= '0;
         end else begin
            if (do_reserve) alloc <= alloc + PW'(1);
            if (do_fill)    fill  <= fill + PW'(1);
            if (do_pop)     head  <= head + PW'(1);
         end
         if (bad_fill) protocol_error <= 1'b1;
      end
   end

   // Storage is not reset; decode outputs are masked while the head is empty.
   always_ff @(posedge clk) begin
      if (do_reserve) pc_mem[alloc[IW-1:0]] <= issue_pc;
      if (do_fill) begin
         instr_mem[fill[IW-1:0]] <= fetch_instruction;
         fault_mem[fill[IW-1:0]] <= ~fetch_address_valid;
      end
   end

   // Fetch must honour the credit: issuing into a full buffer would overwrite
   // the head entry.
   a_no_issue_when_full : assert property (
      @(posedge clk) disable iff (!rst)
      (pc_id_assigned && !flush) |-> pc_id_available
   );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer

module tb_fetch_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        pc_id_available;
   logic        pc_id_assigned = 1'b0;
   logic [31:0] issue_pc = 32'd0;
   logic        fetch_complete = 1'b0;
   logic [31:0] fetch_instruction = 32'd0;
   logic        fetch_address_valid = 1'b1;
   logic        decode_valid;
   logic [31:0] decode_pc;
   logic [31:0] decode_instruction;
   logic        decode_fetch_fault;
   logic        decode_ack = 1'b0;
   logic [2:0]  occupancy;
   logic        protocol_error;

   int checks = 0;
   int passed = 0;

   logic [31:0] pending[$];
   entry_t      filled[$];
   logic        m_perr = 1'b0;

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst                 (rst_n),
      .flush               (flush),
      .pc_id_available     (pc_id_available),
      .pc_id_assigned      (pc_id_assigned),
      .issue_pc            (issue_pc),
      .fetch_complete      (fetch_complete),
      .fetch_instruction   (fetch_instruction),
      .fetch_address_valid (fetch_address_valid),
      .decode_valid        (decode_valid),
      .decode_pc           (decode_pc),
      .decode_instruction  (decode_instruction),
      .decode_fetch_fault  (decode_fetch_fault),
      .decode_ack          (decode_ack),
      .occupancy           (occupancy),
      .protocol_error      (protocol_error)
   );

   function automatic int m_occ();
      return pending.size() + filled.size();
   endfunction

   // Drive one cycle of inputs, advance the model, then land 1 ns after the edge.
   task automatic tick(input logic a, input logic [31:0] p, input logic c,
                       input logic [31:0] ins, input logic av, input logic ack,
                       input logic fl);
      entry_t e;
      logic   dv;
      pc_id_assigned      = a;
      issue_pc            = p;
      fetch_complete      = c;
      fetch_instruction   = ins;
      fetch_address_valid = av;
      decode_ack          = ack;
      flush               = fl;
      dv = (filled.size() > 0);
      if (fl) begin
         pending.delete();
         filled.delete();
      end else begin
         if (ack && dv) void'(filled.pop_front());
         if (c) begin
            if (pending.size() > 0) begin
               e.pc    = pending.pop_front();
               e.instr = ins;
               e.fault = ~av;
               filled.push_back(e);
            end else begin
               m_perr = 1'b1;
            end
         end
         if (a) pending.push_back(p);
      end
      @(posedge clk);
      #1;
      pc_id_assigned      = 1'b0;
      fetch_complete      = 1'b0;
      fetch_address_valid = 1'b1;
      decode_ack          = 1'b0;
      flush               = 1'b0;
   endtask

   task automatic idle();
      tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (pc_id_available !== 1'b1) $display("FAIL reset_avail got %b want 1", pc_id_available); else passed++;
      checks++; if (decode_valid !== 1'b0) $display("FAIL reset_dv got %b want 0", decode_valid); else passed++;
      checks++; if (decode_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", decode_pc); else passed++;
      checks++; if (decode_instruction !== 32'd0) $display("FAIL reset_instr got %h want 0", decode_instruction); else passed++;
      checks++; if (decode_fetch_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", decode_fetch_fault); else passed++;
      checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else passed++;
      checks++; if (protocol_error !== 1'b0) $display("FAIL reset_perr got %b want 0", protocol_error); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      tick(1'b1, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      checks++; if (occupancy !== 3'd1) $display("FAIL single_occ_reserved got %0d want 1", occupancy); else passed++;
      idle();
      checks++; if (decode_valid !== 1'b0) $display("FAIL single_dv_before_fill got %b want 0", decode_valid); else passed++;
      tick(1'b0, 32'd0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
      checks++; if (decode_valid !== 1'b1) $display("FAIL single_dv got %b want 1", decode_valid); else passed++;
      checks++; if (decode_pc !== 32'h8000_0000 || decode_pc !== filled[0].pc) $display("FAIL single_pc got %h want 80000000", decode_pc); else passed++;
      checks++; if (decode_instruction !== 32'h0000_0013) $display("FAIL single_instr got %h want 00000013", decode_instruction); else passed++;
      checks++; if (decode_fetch_fault !== 1'b0) $display("FAIL single_fault got %b want 0", decode_fetch_fault); else passed++;
      tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      checks++; if (occupancy !== 3'd0) $display("FAIL single_occ_after_ack got %0d want 0", occupancy); else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 32'(i * 4), 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
         checks++; if (pc_id_available !== (i < 3)) $display("FAIL b2b_avail_%0d got %b want %b", i, pc_id_available, (i < 3)); else passed++;
      end
      checks++; if (occupancy !== 3'd4) $display("FAIL b2b_occ_full got %0d want 4", occupancy); else passed++;
      for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
      checks++; if (pc_id_available !== 1'b0) $display("FAIL b2b_avail_filled got %b want 0", pc_id_available); else passed++;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (decode_valid !== 1'b1 || decode_pc !== 32'(k * 4) || decode_instruction !== filled[0].instr)
            $display("FAIL b2b_pop_%0d got v=%b pc=%h instr=%h want pc=%h instr=%h", k, decode_valid, decode_pc, decode_instruction, 32'(k * 4), filled[0].instr);
         else passed++;
         tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
         if (k == 0) begin
            checks++; if (pc_id_available !== 1'b1 || occupancy !== 3'd3) $display("FAIL b2b_credit_return got avail=%b occ=%0d want 1/3", pc_id_available, occupancy); else passed++;
         end
      end
      checks++; if (decode_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", decode_valid); else passed++;
   endtask

   task automatic test_fault();
      tick(1'b1, 32'h0000_2000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checks++; if (decode_fetch_fault !== 1'b1) $display("FAIL fault_flag got %b want 1", decode_fetch_fault); else passed++;
      checks++; if (decode_pc !== 32'h0000_2000) $display("FAIL fault_pc got %h want 00002000", decode_pc); else passed++;
      checks++; if (decode_instruction !== 32'hDEAD_BEEF) $display("FAIL fault_instr got %h want deadbeef", decode_instruction); else passed++;
      tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      tick(1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 32'h104, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 32'h108, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b0);
      checks++; if (occupancy !== 3'd3) $display("FAIL flush_pre_occ got %0d want 3", occupancy); else passed++;
      tick(1'b1, 32'h10C, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
      checks++; if (occupancy !== 3'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else passed++;
      checks++; if (decode_valid !== 1'b0) $display("FAIL flush_dv got %b want 0", decode_valid); else passed++;
      checks++; if (pc_id_available !== 1'b1) $display("FAIL flush_avail got %b want 1", pc_id_available); else passed++;
      tick(1'b1, 32'h4000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
      checks++; if (decode_pc !== 32'h4000 || decode_instruction !== 32'h55 || occupancy !== 3'd1)
         $display("FAIL flush_restart got pc=%h instr=%h occ=%0d want 4000/55/1", decode_pc, decode_instruction, occupancy); else passed++;
      tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      int issued = 0;
      int popped = 0;
      int cyc = 0;
      logic a, c, ack;
      while (popped < 20 && cyc < 500) begin
         checks++; if (occupancy !== 3'(m_occ())) $display("FAIL wrap_occ cyc %0d got %0d want %0d", cyc, occupancy, m_occ()); else passed++;
         checks++; if (decode_valid !== (filled.size() > 0)) $display("FAIL wrap_dv cyc %0d got %b want %b", cyc, decode_valid, filled.size() > 0); else passed++;
         a   = (issued < 20) && (m_occ() != DEPTH) && ($urandom_range(0, 3) != 0);
         c   = (pending.size() > 0) && ($urandom_range(0, 2) != 0);
         ack = ($urandom_range(0, 2) != 0);
         if (ack && filled.size() > 0) begin
            checks++;
            if (decode_pc !== filled[0].pc || decode_instruction !== filled[0].instr || decode_pc !== 32'h9000 + 32'(popped * 4))
               $display("FAIL wrap_order pop %0d got pc=%h instr=%h want pc=%h instr=%h", popped, decode_pc, decode_instruction, filled[0].pc, filled[0].instr);
            else passed++;
            popped++;
         end
         tick(a, 32'h9000 + 32'(issued * 4), c, 32'hC000_0000 + 32'($urandom_range(0, 65535)), 1'b1, ack, 1'b0);
         if (a) issued++;
         cyc++;
      end
      checks++; if (popped != 20) $display("FAIL wrap_timeout popped %0d want 20", popped); else passed++;
   endtask

   task automatic test_protocol_error();
      tick(1'b0, 32'd0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      checks++; if (protocol_error !== 1'b1 || protocol_error !== m_perr) $display("FAIL perr_set got %b want 1", protocol_error); else passed++;
      checks++; if (decode_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL perr_no_change got dv=%b occ=%0d want 0/0", decode_valid, occupancy); else passed++;
      tick(1'b1, 32'h6000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
      checks++; if (protocol_error !== 1'b1) $display("FAIL perr_sticky got %b want 1", protocol_error); else passed++;
      checks++; if (decode_pc !== 32'h6000 || decode_instruction !== 32'h66) $display("FAIL perr_after got pc=%h instr=%h want 6000/66", decode_pc, decode_instruction); else passed++;
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 32'h7000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if (occupancy !== 3'd0 || decode_valid !== 1'b0) $display("FAIL rst_mid_state got occ=%0d dv=%b want 0/0", occupancy, decode_valid); else passed++;
      checks++; if (protocol_error !== 1'b0) $display("FAIL rst_mid_perr got %b want 0", protocol_error); else passed++;
      pending.delete();
      filled.delete();
      m_perr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick(1'b1, 32'h7100, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 1'b1, 32'h71, 1'b1, 1'b0, 1'b0);
      checks++; if (decode_pc !== 32'h7100 || occupancy !== 3'd1) $display("FAIL rst_mid_restart got pc=%h occ=%0d want 7100/1", decode_pc, occupancy); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fault();
      test_flush();
      test_wrap();
      test_protocol_error();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
